// File: rtl/f_node_acc.sv
// First-layer F node: accumulates one frame of serial binary pixels into CH
// signed per-channel sums and hands them downstream over a valid/ready port.
module f_node_acc #(
  parameter int N     = 5,
  parameter int CH    = 16,
  parameter int PIX   = 784,
  parameter int ACC_W = 15,
  parameter int MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    pix,
  input  logic [CH*N-1:0]         w_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH*ACC_W-1:0]     sum_out,
  output logic [$clog2(PIX)-1:0]  pix_cnt
);

  localparam int CNT_W = $clog2(PIX);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CH*ACC_W-1:0]   acc_q, acc_d;
  logic [CH*ACC_W-1:0]   term;
  logic                  accept;
  logic                  last_beat;

  // Per-channel contribution of the current beat, sign-extended to ACC_W so
  // negating the most negative weight stays exact.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [N-1:0]     w;
    logic [ACC_W-1:0] w_ext;
    assign w     = w_in[c*N +: N];
    assign w_ext = {{(ACC_W-N){w[N-1]}}, w};
    assign term[c*ACC_W +: ACC_W] = pix ? w_ext
                                        : ((MODE == 1) ? -w_ext : '0);
  end

  // Handshake flags come straight from the state register, so neither ready
  // nor valid has a combinational path from an input.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == CNT_W'(PIX - 1));
  assign sum_out   = acc_q;
  assign pix_cnt   = cnt_q;

  // NOTE: every signal driven here gets a default first so no path can
  // infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          for (int c = 0; c < CH; c++) begin
            acc_d[c*ACC_W +: ACC_W] = acc_q[c*ACC_W +: ACC_W]
                                    + term[c*ACC_W +: ACC_W];
          end
          if (last_beat) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        // Sums stay frozen until downstream takes them; clearing on the
        // transfer lets the next frame start on the following cycle.
        if (out_ready) begin
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the
  // accumulators are plain registers and are reset so a frame cut short by
  // reset cannot leak into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_f_node_acc.sv
// Self-checking bench for f_node_acc: gated and bipolar instances share the
// same stimulus and are compared against a frame-level reference model.
module tb_f_node_acc;

  localparam int N     = 4;
  localparam int CH    = 2;
  localparam int PIX   = 4;
  localparam int ACC_W = 7;
  localparam int CNT_W = $clog2(PIX);

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic pix;
  logic out_ready;
  logic signed [N-1:0] w0, w1;
  logic [CH*N-1:0] w_in;

  logic                 in_ready_g, out_valid_g, in_ready_b, out_valid_b;
  logic [CH*ACC_W-1:0]  sum_g, sum_b;
  logic [CNT_W-1:0]     cnt_g, cnt_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: beats accepted this frame, whether a finished frame is
  // waiting downstream, and the running signed sums for each mode.
  int  m_cnt;
  bit  m_hold;
  int  m_sum_g [CH];
  int  m_sum_b [CH];

  assign w_in = {w1, w0};

  always #5 clk = ~clk;

  f_node_acc #(.N(N), .CH(CH), .PIX(PIX), .ACC_W(ACC_W), .MODE(0)) dut_g (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_g),
    .pix(pix), .w_in(w_in), .out_valid(out_valid_g), .out_ready(out_ready),
    .sum_out(sum_g), .pix_cnt(cnt_g)
  );

  f_node_acc #(.N(N), .CH(CH), .PIX(PIX), .ACC_W(ACC_W), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .pix(pix), .w_in(w_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .sum_out(sum_b), .pix_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wrap(input int v);
    return 32'(v) & ((32'd1 << ACC_W) - 32'd1);
  endfunction

  task automatic model_clear();
    m_cnt  = 0;
    m_hold = 0;
    for (int c = 0; c < CH; c++) begin
      m_sum_g[c] = 0;
      m_sum_b[c] = 0;
    end
  endtask

  task automatic check_all();
    chk("in_ready_g",  {31'd0, in_ready_g},  {31'd0, !m_hold});
    chk("out_valid_g", {31'd0, out_valid_g}, {31'd0, m_hold});
    chk("pix_cnt_g",   32'(cnt_g), 32'(m_cnt));
    chk("in_ready_b",  {31'd0, in_ready_b},  {31'd0, !m_hold});
    chk("out_valid_b", {31'd0, out_valid_b}, {31'd0, m_hold});
    chk("pix_cnt_b",   32'(cnt_b), 32'(m_cnt));
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("sum_g[%0d]", c), 32'(sum_g[c*ACC_W +: ACC_W]), wrap(m_sum_g[c]));
      chk($sformatf("sum_b[%0d]", c), 32'(sum_b[c*ACC_W +: ACC_W]), wrap(m_sum_b[c]));
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check #1 later.
  task automatic cycle(input bit iv, input bit p, input int wa, input int wb, input bit ordy);
    int wv [CH];
    in_valid  = iv;
    pix       = p;
    w0        = N'(wa);
    w1        = N'(wb);
    out_ready = ordy;
    wv[0] = int'(w0);
    wv[1] = int'(w1);
    @(posedge clk);
    if (!m_hold) begin
      if (iv) begin
        for (int c = 0; c < CH; c++) begin
          m_sum_g[c] += p ? wv[c] : 0;
          m_sum_b[c] += p ? wv[c] : -wv[c];
        end
        m_cnt++;
        if (m_cnt == PIX) begin
          m_cnt  = 0;
          m_hold = 1;
        end
      end
    end else if (ordy) begin
      model_clear();
    end
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int holds;
  int snap_g0;
  int frame_pix [4];

  initial begin
    rst = 1'b1; in_valid = 0; pix = 0; w0 = '0; w1 = '0; out_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Put some state in, then reset mid-cycle with no clock edge.
    cycle(1, 1, 5, -3, 0);
    cycle(1, 1, 2, 1, 0);
    async_reset();

    // Gated/bipolar frame: pix 1,0,1,1, weights +3/-2 -> 9/-6 and 6/-4.
    frame_pix = '{1, 0, 1, 1};
    for (int i = 0; i < PIX; i++) cycle(1, frame_pix[i], 3, -2, 0);
    chk("hold_sum_g0", 32'(sum_g[0 +: ACC_W]), wrap(9));
    chk("hold_sum_g1", 32'(sum_g[ACC_W +: ACC_W]), wrap(-6));
    chk("hold_sum_b0", 32'(sum_b[0 +: ACC_W]), wrap(6));
    chk("hold_sum_b1", 32'(sum_b[ACC_W +: ACC_W]), wrap(-4));
    cycle(0, 0, 0, 0, 1);

    // Bipolar with most negative weight on every pixel=0 beat -> +32.
    for (int i = 0; i < PIX; i++) cycle(1, 0, -8, 7, 0);
    chk("neg_max_b0", 32'(sum_b[0 +: ACC_W]), wrap(32));
    cycle(0, 0, 0, 0, 1);

    // Gapped input 1,0,0,1,... then backpressure with in_valid held high.
    for (int i = 0; i < 3 * PIX; i++) cycle(i % 3 == 0, 1'($urandom), $urandom_range(15), $urandom_range(15), 0);
    snap_g0 = int'(sum_g[0 +: ACC_W]);
    for (int i = 0; i < 5; i++) cycle(1, 1, 7, 7, 0);
    chk("stable_sum_g0", 32'(sum_g[0 +: ACC_W]), 32'(snap_g0));
    cycle(1, 1, 7, 7, 1);

    // Back-to-back frames: count in_ready low cycles across three frames.
    holds = 0;
    for (int i = 0; i < 3 * (PIX + 1); i++) begin
      cycle(1, 1'($urandom), $urandom_range(15), $urandom_range(15), 1);
      if (!in_ready_g) holds++;
    end
    chk("b2b_hold_cycles", 32'(holds), 32'd3);

    // Reset after two of four beats; the following frame must stand alone.
    cycle(1, 1, 6, 6, 1);
    cycle(1, 1, 6, 6, 1);
    async_reset();
    for (int i = 0; i < PIX; i++) cycle(1, 1, 1, -1, 0);
    chk("post_reset_g0", 32'(sum_g[0 +: ACC_W]), wrap(4));
    chk("post_reset_b1", 32'(sum_b[ACC_W +: ACC_W]), wrap(-4));
    cycle(0, 0, 0, 0, 1);

    // Random traffic on every input.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom), 1'($urandom), $urandom_range(15), $urandom_range(15), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
